// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp
// Purpose  : Word-organised data RAM for the RV32 execute-stage load/store
//            port. It serves one access at a time with WAIT_CYCLES busy
//            cycles, requests a pipeline stall while an access is
//            outstanding, and returns a one-cycle response strobe.
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous reset, active low
//            req_i    - request valid (sampled in IDLE only)
//            we_i     - 1 = write, 0 = read
//            raddr_i  - read byte address
//            waddr_i  - write byte address
//            wdata_i  - write data (full word)
//            rdata_o  - registered read data, held until the next read
//            ready_o  - one-cycle response strobe
//            err_o    - out-of-range flag, valid with ready_o
//            hold_o   - pipeline stall request
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] raddr_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        hold_o
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] C_LOAD    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       C_NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_idle;
    logic          w_accept;
    logic          w_commit;
    logic [31:0]   w_sel_addr;
    logic          w_c_we;
    logic [31:0]   w_c_addr;
    logic [31:0]   w_c_wdata;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_unused;

    // Acceptance is blocked while reset is asserted so no stall is requested
    // and no RAM write can sneak in during reset.
    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = rst & w_idle & req_i;
    assign w_sel_addr = we_i ? waddr_i : raddr_i;

    // With zero wait states the commit happens on the accept edge itself, so
    // the operands come straight from the inputs instead of the capture regs.
    assign w_commit  = (w_accept & C_NO_WAIT) | ((r_state == S_BUSY) && (r_cnt == 4'd0));
    assign w_c_we    = w_idle ? we_i       : r_we;
    assign w_c_addr  = w_idle ? w_sel_addr : r_addr;
    assign w_c_wdata = w_idle ? wdata_i    : r_wdata;

    // Byte offset bits are ignored; anything above the RAM span is an error.
    assign w_idx    = w_c_addr[AW+1:2];
    assign w_oor    = |(w_c_addr >> (AW + 2));
    assign w_unused = ^w_c_addr[1:0];

    assign hold_o = w_accept | (r_state == S_BUSY);

    // RAM array: no reset, contents undefined at power-up.
    always_ff @(posedge clk) begin
        if (w_commit && w_c_we && !w_oor) begin
            r_mem[w_idx] <= w_c_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            rdata_o <= 32'd0;
            ready_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_addr  <= w_sel_addr;
                        r_wdata <= wdata_i;
                        if (C_NO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= C_LOAD;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // ready/err are high exactly for the RESP cycle that follows a commit.
            ready_o <= w_commit;
            err_o   <= w_commit & w_oor;
            if (w_commit && !w_c_we) begin
                rdata_o <= w_oor ? 32'd0 : r_mem[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_resp
// Purpose  : Self-checking bench for dmem_resp. Two instances are exercised,
//            one with two wait states and one with none, against a word-array
//            reference model of the memory, the read-data register and the
//            expected response timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

    localparam int DEPTH = 4096;
    localparam int W_A   = 2;
    localparam int W_B   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] raddr [2];
    logic [31:0] waddr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        hold  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: first 16 words of each RAM and each rdata_o register.
    logic [31:0] mdl    [2][16];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) u_dut_w2 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]),
        .raddr_i(raddr[0]), .waddr_i(waddr[0]), .wdata_i(wdata[0]),
        .rdata_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0]), .hold_o(hold[0])
    );

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_B)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]),
        .raddr_i(raddr[1]), .waddr_i(waddr[1]), .wdata_i(wdata[1]),
        .rdata_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1]), .hold_o(hold[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 0) ? W_A : W_B;
    endfunction

    // One complete access. Entered and left at posedge+1 with the DUT in IDLE.
    task automatic do_txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
        int  k;
        int  hc;
        bit  oor;
        int  idx;
        oor = (a >= 32'(DEPTH * 4));
        idx = int'((a % 32'(DEPTH * 4)) / 4);
        if (!oor && w) mdl[s][idx] = d;
        if (!w) exp_rd[s] = oor ? 32'd0 : mdl[s][idx];

        req[s]   = 1'b1;
        we[s]    = w;
        raddr[s] = w ? $urandom : a;
        waddr[s] = w ? a : $urandom;
        wdata[s] = w ? d : $urandom;
        #1;
        hc = hold[s] ? 1 : 0;
        check_eq($sformatf("hold_accept[%0d]", s), 32'(hold[s]), 32'd1);

        @(posedge clk); #1;
        k = 1;
        // Inputs are scrambled after acceptance; only captured values count.
        req[s]   = 1'b0;
        raddr[s] = $urandom;
        waddr[s] = $urandom;
        wdata[s] = $urandom;
        while (!ready[s] && k < 40) begin
            hc += hold[s] ? 1 : 0;
            @(posedge clk); #1;
            k++;
        end
        check_eq($sformatf("latency[%0d]", s), 32'(k), 32'(wait_of(s) + 1));
        check_eq($sformatf("hold_cycles[%0d]", s), 32'(hc), 32'(wait_of(s) + 1));
        check_eq($sformatf("hold_resp[%0d]", s), 32'(hold[s]), 32'd0);
        check_eq($sformatf("err[%0d] a=%h", s, a), 32'(err[s]), 32'(oor));
        check_eq($sformatf("rdata[%0d] a=%h", s, a), rdata[s], exp_rd[s]);

        @(posedge clk); #1;
        check_eq($sformatf("ready_pulse[%0d]", s), 32'(ready[s]), 32'd0);
        check_eq($sformatf("err_clear[%0d]", s), 32'(err[s]), 32'd0);
    endtask

    // req_i held high across two reads of word 1 and word 2.
    task automatic back_to_back(input int s);
        int k;
        req[s]   = 1'b1;
        we[s]    = 1'b0;
        raddr[s] = 32'h4;
        k = 0;
        @(posedge clk); #1;
        while (!ready[s] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        exp_rd[s] = mdl[s][1];
        check_eq($sformatf("b2b_first[%0d]", s), rdata[s], exp_rd[s]);
        check_eq($sformatf("b2b_hold_resp[%0d]", s), 32'(hold[s]), 32'd0);
        raddr[s] = 32'h8;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                check_eq($sformatf("b2b_idle_ready[%0d]", s), 32'(ready[s]), 32'd0);
                check_eq($sformatf("b2b_idle_hold[%0d]", s), 32'(hold[s]), 32'd1);
            end
            if (k == 2) req[s] = 1'b0;
        end while (!ready[s] && k < 40);
        req[s] = 1'b0;
        check_eq($sformatf("b2b_gap[%0d]", s), 32'(k), 32'(wait_of(s) + 2));
        exp_rd[s] = mdl[s][2];
        check_eq($sformatf("b2b_second[%0d]", s), rdata[s], exp_rd[s]);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0;
            raddr[s] = '0; waddr[s] = '0; wdata[s] = '0;
            exp_rd[s] = '0;
        end
        rst = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            check_eq($sformatf("rst_rdata[%0d]", s), rdata[s], 32'd0);
            check_eq($sformatf("rst_ready[%0d]", s), 32'(ready[s]), 32'd0);
            check_eq($sformatf("rst_err[%0d]", s), 32'(err[s]), 32'd0);
            check_eq($sformatf("rst_hold[%0d]", s), 32'(hold[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Fill the modelled region of both RAMs.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                do_txn(s, 1'b1, 32'(i * 4), $urandom);

        // Write then read with byte offset ignored.
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_txn(0, 1'b0, 32'h13, 32'h0);
        // Zero-wait read.
        do_txn(1, 1'b0, 32'h13, 32'h0);
        // Out of range write leaves RAM alone; out of range read returns 0.
        do_txn(0, 1'b0, 32'h0, 32'h0);
        do_txn(0, 1'b1, 32'h0000_4000, 32'h12345678);
        do_txn(0, 1'b0, 32'h0, 32'h0);
        do_txn(0, 1'b0, 32'h0000_4000, 32'h0);
        do_txn(1, 1'b1, 32'h0000_4000, 32'h12345678);
        do_txn(1, 1'b0, 32'h0000_4000, 32'h0);

        back_to_back(0);
        back_to_back(1);

        // Reset during BUSY drops the pending write.
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        waddr[0] = 32'h20;
        wdata[0] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req[0] = 1'b0;
        #2;
        rst = 1'b0;
        req[0] = 1'b1;
        req[1] = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            check_eq($sformatf("midrst_rdata[%0d]", s), rdata[s], 32'd0);
            check_eq($sformatf("midrst_ready[%0d]", s), 32'(ready[s]), 32'd0);
            check_eq($sformatf("midrst_err[%0d]", s), 32'(err[s]), 32'd0);
            check_eq($sformatf("midrst_hold[%0d]", s), 32'(hold[s]), 32'd0);
            exp_rd[s] = 32'd0;
        end
        @(negedge clk);
        req[0] = 1'b0;
        req[1] = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check_eq("postrst_ready", 32'(ready[0]), 32'd0);
        end
        do_txn(0, 1'b0, 32'h20, 32'h0);

        // Randomised accesses against the model.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                int          op;
                logic [31:0] a;
                op = $urandom_range(0, 3);
                case (op)
                    0: begin
                        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                        do_txn(s, 1'b1, a, $urandom);
                    end
                    1, 2: begin
                        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                        do_txn(s, 1'b0, a, 32'h0);
                    end
                    default: begin
                        a = $urandom | 32'h0000_4000;
                        do_txn(s, 1'($urandom_range(0, 1)), a, $urandom);
                    end
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
